// File: rtl/common.sv
// Shared pipeline types, memory-stage FSM states and load/store size encodings.
package common;

  typedef struct packed {
    logic       stall_req;
    logic [3:0] flush_req;
  } PipeRequest;

  typedef struct packed {
    logic stall;
    logic flush;
  } PipeControl;

  typedef struct packed {
    logic       enable;
    logic       mem_read;
    logic       mem_write;
    logic [2:0] funct3;
    logic       rd_valid;
    logic [4:0] rd;
  } DecodeInfo;

  typedef enum logic [2:0] {
    MEM_IDLE,
    MEM_REQ,
    MEM_RESP,
    MEM_DONE,
    MEM_DRAIN
  } MemState;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  // Unsupported sizes are treated like misaligned accesses: no bus cycle.
  function automatic logic lsu_misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      LSU_B, LSU_BU: return 1'b0;
      LSU_H, LSU_HU: return a[0];
      LSU_W:         return a != 2'b00;
      default:       return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store enables/replication and load lane extract/extend.
module lsu_align
  import common::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_lane,
  input  logic [31:0] i_store_data,
  input  logic [31:0] i_load_word,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_load_data
);

  logic [31:0] w_shift;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_shift = i_load_word >> {i_lane, 3'b000};
  assign w_byte  = w_shift[7:0];
  assign w_half  = w_shift[15:0];

  always_comb begin
    o_be        = 4'b0000;
    o_wdata     = '0;
    o_load_data = '0;
    case (i_funct3)
      LSU_B, LSU_BU: begin
        o_be        = 4'b0001 << i_lane;
        o_wdata     = {4{i_store_data[7:0]}};
        o_load_data = (i_funct3 == LSU_B) ? {{24{w_byte[7]}}, w_byte} : {24'h0, w_byte};
      end
      LSU_H, LSU_HU: begin
        o_be        = i_lane[1] ? 4'b1100 : 4'b0011;
        o_wdata     = {2{i_store_data[15:0]}};
        o_load_data = (i_funct3 == LSU_H) ? {{16{w_half[15]}}, w_half} : {16'h0, w_half};
      end
      LSU_W: begin
        o_be        = 4'b1111;
        o_wdata     = i_store_data;
        o_load_data = i_load_word;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Memory pipeline stage: issues data-bus accesses, stalls until the response,
// and registers the stage result and instruction info for writeback.
module mem_access
  import common::*;
(
  input  logic        clk,
  input  logic        rst,
  output PipeRequest  req,
  input  PipeControl  pipe,
  input  DecodeInfo   info,
  input  logic [31:0] alu_out,
  input  logic [31:0] r2_out,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_be,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_gnt,
  input  logic        dbus_rvalid,
  input  logic [31:0] dbus_rdata,
  output logic [31:0] mem_out,
  output DecodeInfo   info_ff,
  output logic        misalign
);

  MemState     r_state;
  logic        r_we;
  logic [31:0] r_addr, r_wdata, r_buf;
  logic [3:0]  r_be;
  logic [2:0]  r_funct3;
  logic [1:0]  r_lane;

  logic        w_is_mem, w_mis, w_access, w_issue, w_rsp_done;
  logic [2:0]  w_funct3;
  logic [1:0]  w_lane;
  logic [3:0]  w_be;
  logic [31:0] w_wdata, w_load_data, w_result;
  DecodeInfo   w_info_pass;

  assign w_is_mem   = info.enable & (info.mem_read | info.mem_write);
  assign w_mis      = w_is_mem & lsu_misaligned(info.funct3, alu_out[1:0]);
  assign w_access   = w_is_mem & ~w_mis;
  assign w_issue    = (r_state == MEM_IDLE) & w_access & ~pipe.flush;
  assign w_rsp_done = (r_state == MEM_RESP) & dbus_rvalid;

  // Store side is steered from live inputs at issue; load side from the captured access.
  assign w_funct3 = (r_state == MEM_IDLE) ? info.funct3 : r_funct3;
  assign w_lane   = (r_state == MEM_IDLE) ? alu_out[1:0] : r_lane;

  lsu_align u_align (
    .i_funct3    (w_funct3),
    .i_lane      (w_lane),
    .i_store_data(r2_out),
    .i_load_word (dbus_rdata),
    .o_be        (w_be),
    .o_wdata     (w_wdata),
    .o_load_data (w_load_data)
  );

  assign w_result = r_we ? alu_out : w_load_data;

  always_comb begin
    w_info_pass          = info;
    w_info_pass.rd_valid = info.rd_valid & ~w_mis;
    dbus_req   = 1'b0;
    dbus_we    = 1'b0;
    dbus_addr  = '0;
    dbus_be    = 4'b0000;
    dbus_wdata = '0;
    if (w_issue) begin
      dbus_req   = 1'b1;
      dbus_we    = info.mem_write;
      dbus_addr  = {alu_out[31:2], 2'b00};
      dbus_be    = w_be;
      dbus_wdata = info.mem_write ? w_wdata : '0;
    end else if (r_state == MEM_REQ) begin
      dbus_req   = 1'b1;
      dbus_we    = r_we;
      dbus_addr  = r_addr;
      dbus_be    = r_be;
      dbus_wdata = r_wdata;
    end
  end

  // A fresh access arriving while an abandoned response drains is held back.
  always_comb begin
    req = '0;
    case (r_state)
      MEM_IDLE:  req.stall_req = w_issue;
      MEM_REQ:   req.stall_req = 1'b1;
      MEM_RESP:  req.stall_req = ~dbus_rvalid & ~pipe.flush;
      MEM_DRAIN: req.stall_req = w_access;
      default:   req.stall_req = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= MEM_IDLE;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_be     <= 4'b0000;
      r_wdata  <= '0;
      r_funct3 <= 3'b000;
      r_lane   <= 2'b00;
      r_buf    <= '0;
      mem_out  <= '0;
      info_ff  <= '0;
      misalign <= 1'b0;
    end else begin
      case (r_state)
        MEM_IDLE: if (w_issue) begin
          r_we     <= info.mem_write;
          r_addr   <= {alu_out[31:2], 2'b00};
          r_be     <= w_be;
          r_wdata  <= info.mem_write ? w_wdata : '0;
          r_funct3 <= info.funct3;
          r_lane   <= alu_out[1:0];
          r_state  <= dbus_gnt ? MEM_RESP : MEM_REQ;
        end
        MEM_REQ: begin
          if (dbus_gnt)        r_state <= pipe.flush ? MEM_DRAIN : MEM_RESP;
          else if (pipe.flush) r_state <= MEM_IDLE;
        end
        MEM_RESP: begin
          if (dbus_rvalid) begin
            r_buf   <= w_result;
            r_state <= (pipe.stall & ~pipe.flush) ? MEM_DONE : MEM_IDLE;
          end else if (pipe.flush) begin
            r_state <= MEM_DRAIN;
          end
        end
        MEM_DONE:  if (pipe.flush | ~pipe.stall) r_state <= MEM_IDLE;
        MEM_DRAIN: if (dbus_rvalid) r_state <= MEM_IDLE;
        default:   r_state <= MEM_IDLE;
      endcase

      misalign <= 1'b0;
      if (pipe.flush) begin
        mem_out <= '0;
        info_ff <= '0;
      end else if (!pipe.stall) begin
        if (r_state == MEM_DONE) begin
          mem_out <= r_buf;
          info_ff <= info;
        end else if (w_rsp_done) begin
          mem_out <= w_result;
          info_ff <= info;
        end else if (w_access) begin
          mem_out <= '0;
          info_ff <= '0;
        end else begin
          mem_out  <= w_mis ? '0 : alu_out;
          info_ff  <= w_info_pass;
          misalign <= w_mis;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: vector table plus hand-built stall/flush/reset sequences.
module tb_mem_access;
  import common::*;

  logic        clk = 1'b0;
  logic        rst;
  PipeRequest  req;
  PipeControl  pipe;
  DecodeInfo   info;
  logic [31:0] alu_out, r2_out;
  logic        dbus_req, dbus_we, dbus_gnt, dbus_rvalid;
  logic [31:0] dbus_addr, dbus_wdata, dbus_rdata, mem_out;
  logic [3:0]  dbus_be;
  DecodeInfo   info_ff;
  logic        misalign;

  mem_access dut (
    .clk(clk), .rst(rst), .req(req), .pipe(pipe), .info(info),
    .alu_out(alu_out), .r2_out(r2_out),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
    .dbus_be(dbus_be), .dbus_wdata(dbus_wdata), .dbus_gnt(dbus_gnt),
    .dbus_rvalid(dbus_rvalid), .dbus_rdata(dbus_rdata),
    .mem_out(mem_out), .info_ff(info_ff), .misalign(misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f3;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] alu;
    logic [31:0] r2;
    logic [31:0] rdata;
    logic [31:0] exp_out;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic        exp_bus;
    logic        exp_mis;
  } vec_t;

  typedef struct {
    logic [31:0] mem_out;
    logic        rd_valid;
    logic        mis;
    logic [4:0]  rd;
  } exp_t;

  int   tests = 0;
  int   fails = 0;
  exp_t sbq[$];
  logic prev_hold = 1'b1;
  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk) prev_hold <= pipe.stall | pipe.flush;

  // Each fresh (non-held) output with enable set retires one scoreboard entry.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && !prev_hold && info_ff.enable) begin
      if (sbq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_unexpected: got output %h expected none", mem_out);
      end else begin
        e = sbq.pop_front();
        check("sb_mem_out", mem_out, e.mem_out);
        check("sb_rd_valid", 32'(info_ff.rd_valid), 32'(e.rd_valid));
        check("sb_misalign", 32'(misalign), 32'(e.mis));
        check("sb_rd", 32'(info_ff.rd), 32'(e.rd));
      end
    end
  end

  task automatic idle(input int n);
    info    = '0;
    alu_out = '0;
    r2_out  = '0;
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge after the instruction retires.
  task automatic run_vec(input vec_t v, input int idx, input int gnt_dly, input int rv_dly,
                         input int post_stall);
    DecodeInfo   d;
    exp_t        e;
    logic [31:0] exp_addr;
    d          = '0;
    d.enable   = 1'b1;
    d.mem_read = v.rd_en;
    d.mem_write = v.wr_en;
    d.funct3   = v.f3;
    d.rd_valid = ~v.wr_en;
    d.rd       = 5'(idx + 1);
    exp_addr   = v.alu & 32'hFFFF_FFFC;
    info = d; alu_out = v.alu; r2_out = v.r2;
    e.mem_out = v.exp_out; e.rd_valid = ~v.wr_en & ~v.exp_mis; e.mis = v.exp_mis; e.rd = d.rd;
    sbq.push_back(e);
    #1;
    if (!v.exp_bus) begin
      check("nobus_dbus_req", 32'(dbus_req), 0);
      check("nobus_stall_req", 32'(req.stall_req), 0);
      @(negedge clk);
    end else begin
      for (int n = 0; n <= gnt_dly; n++) begin
        check("req_dbus_req", 32'(dbus_req), 1);
        check("req_stall_req", 32'(req.stall_req), 1);
        check("req_we", 32'(dbus_we), 32'(v.wr_en));
        check("req_addr", dbus_addr, exp_addr);
        if (v.wr_en) begin
          check("req_be", 32'(dbus_be), 32'(v.exp_be));
          check("req_wdata", dbus_wdata, v.exp_wdata);
        end
        dbus_gnt = (n == gnt_dly);
        @(negedge clk);
        dbus_gnt = 1'b0;
        #1;
      end
      for (int k = 1; k < rv_dly; k++) begin
        check("resp_no_reissue", 32'(dbus_req), 0);
        check("resp_stall_req", 32'(req.stall_req), 1);
        check("resp_addr_zero", dbus_addr, 0);
        @(negedge clk);
        #1;
      end
      dbus_rvalid = 1'b1;
      dbus_rdata  = v.rdata;
      pipe.stall  = (post_stall > 0);
      #1;
      check("rvalid_stall_req", 32'(req.stall_req), 0);
      @(negedge clk);
      dbus_rvalid = 1'b0;
      dbus_rdata  = '0;
      if (post_stall > 0) begin
        for (int k = 1; k <= post_stall; k++) begin
          #1;
          check("done_stall_req", 32'(req.stall_req), 0);
          check("done_no_reissue", 32'(dbus_req), 0);
          @(negedge clk);
        end
        pipe.stall = 1'b0;
        #1;
        check("done_release_stall_req", 32'(req.stall_req), 0);
        check("done_release_no_reissue", 32'(dbus_req), 0);
        @(negedge clk);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    DecodeInfo d;
    vec_t      v;
    rst = 1'b1; pipe = '0; info = '0; alu_out = '0; r2_out = '0;
    dbus_gnt = 1'b0; dbus_rvalid = 1'b0; dbus_rdata = '0;

    vecs[0]  = '{LSU_W,  1, 0, 32'h100, 0, 32'hDEADBEEF, 32'hDEADBEEF, 4'hF, 0, 1, 0};
    vecs[1]  = '{LSU_B,  1, 0, 32'h103, 0, 32'h80112233, 32'hFFFFFF80, 4'h0, 0, 1, 0};
    vecs[2]  = '{LSU_BU, 1, 0, 32'h103, 0, 32'h80112233, 32'h00000080, 4'h0, 0, 1, 0};
    vecs[3]  = '{LSU_HU, 1, 0, 32'h102, 0, 32'h80112233, 32'h00008011, 4'h0, 0, 1, 0};
    vecs[4]  = '{LSU_H,  1, 0, 32'h100, 0, 32'h80118899, 32'hFFFF8899, 4'h0, 0, 1, 0};
    vecs[5]  = '{LSU_B,  1, 0, 32'h101, 0, 32'h80112233, 32'h00000022, 4'h0, 0, 1, 0};
    vecs[6]  = '{LSU_H,  1, 0, 32'h102, 0, 32'h7FFF0000, 32'h00007FFF, 4'h0, 0, 1, 0};
    vecs[7]  = '{LSU_H,  0, 1, 32'h202, 32'h1234ABCD, 32'hFFFFFFFF, 32'h202, 4'b1100, 32'hABCDABCD, 1, 0};
    vecs[8]  = '{LSU_B,  0, 1, 32'h201, 32'h000000A5, 0, 32'h201, 4'b0010, 32'hA5A5A5A5, 1, 0};
    vecs[9]  = '{LSU_W,  0, 1, 32'h204, 32'hCAFEF00D, 0, 32'h204, 4'b1111, 32'hCAFEF00D, 1, 0};
    vecs[10] = '{LSU_B,  0, 0, 32'h12345678, 0, 0, 32'h12345678, 4'h0, 0, 0, 0};
    vecs[11] = '{LSU_W,  1, 0, 32'h101, 0, 0, 32'h0, 4'h0, 0, 0, 1};
    vecs[12] = '{LSU_H,  1, 0, 32'h103, 0, 0, 32'h0, 4'h0, 0, 0, 1};
    vecs[13] = '{3'b011, 1, 0, 32'h100, 0, 0, 32'h0, 4'h0, 0, 0, 1};
    vecs[14] = '{LSU_W,  0, 1, 32'h206, 32'h1, 0, 32'h0, 4'h0, 0, 0, 1};

    repeat (2) @(negedge clk);
    #1;
    check("rst_dbus_req", 32'(dbus_req), 0);
    check("rst_stall_req", 32'(req.stall_req), 0);
    check("rst_flush_req", 32'(req.flush_req), 0);
    check("rst_mem_out", mem_out, 0);
    check("rst_info_ff", 32'(info_ff), 0);
    check("rst_misalign", 32'(misalign), 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 15; i++) run_vec(vecs[i], i, 0, 1, 0);
    idle(1);
    #1;
    check("misalign_pulse_end", 32'(misalign), 0);
    @(negedge clk);

    // Slow grant, slow response, downstream stall holding the result in DONE.
    v = '{LSU_W, 1, 0, 32'h300, 0, 32'h0BADF00D, 32'h0BADF00D, 4'h0, 0, 1, 0};
    run_vec(v, 20, 3, 2, 2);
    idle(2);
    check("sb_empty_after_done", 32'(sbq.size()), 0);

    // Flush while waiting for the response; the late data must be discarded.
    d = '0; d.enable = 1'b1; d.mem_read = 1'b1; d.funct3 = LSU_W; d.rd_valid = 1'b1; d.rd = 5'd25;
    info = d; alu_out = 32'h108;
    #1;
    check("flush_issue_req", 32'(dbus_req), 1);
    dbus_gnt = 1'b1;
    @(negedge clk);
    dbus_gnt = 1'b0;
    pipe.flush = 1'b1;
    @(negedge clk);
    pipe.flush = 1'b0;
    info = '0; alu_out = '0;
    #1;
    check("drain_stall_req", 32'(req.stall_req), 0);
    check("drain_no_req", 32'(dbus_req), 0);
    dbus_rvalid = 1'b1; dbus_rdata = 32'h55AA55AA;
    @(negedge clk);
    dbus_rvalid = 1'b0; dbus_rdata = '0;
    #1;
    check("drain_mem_out", mem_out, 0);
    check("drain_info_en", 32'(info_ff.enable), 0);
    v = '{LSU_W, 1, 0, 32'h104, 0, 32'h11112222, 32'h11112222, 4'h0, 0, 1, 0};
    run_vec(v, 21, 0, 1, 0);

    // Reset in RESP with the stage held, then a stray response afterwards.
    d = '0; d.enable = 1'b1; d.mem_read = 1'b1; d.funct3 = LSU_W; d.rd_valid = 1'b1; d.rd = 5'd30;
    pipe.stall = 1'b1; info = d; alu_out = 32'h180;
    #1;
    check("rst_seq_issue_req", 32'(dbus_req), 1);
    dbus_gnt = 1'b1;
    @(negedge clk);
    dbus_gnt = 1'b0;
    #1;
    check("rst_seq_held_out", mem_out, 32'h11112222);
    rst = 1'b1; pipe = '0; info = '0; alu_out = '0;
    #1;
    check("rst_seq_dbus_req", 32'(dbus_req), 0);
    check("rst_seq_mem_out", mem_out, 0);
    check("rst_seq_info_ff", 32'(info_ff), 0);
    @(negedge clk);
    rst = 1'b0;
    dbus_rvalid = 1'b1; dbus_rdata = 32'h77777777;
    #1;
    check("stray_stall_req", 32'(req.stall_req), 0);
    check("stray_dbus_req", 32'(dbus_req), 0);
    @(negedge clk);
    dbus_rvalid = 1'b0; dbus_rdata = '0;
    #1;
    check("stray_mem_out", mem_out, 0);
    check("stray_info_en", 32'(info_ff.enable), 0);
    v = '{LSU_BU, 1, 0, 32'h102, 0, 32'h00AB0000, 32'h000000AB, 4'h0, 0, 1, 0};
    run_vec(v, 22, 0, 1, 0);

    idle(3);
    check("sb_empty_end", 32'(sbq.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 No parameters.
REQ-002 clk  in  1  sole clock; all state updates on posedge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 req  out  PipeRequest  stall_req while a bus access is outstanding; flush_req SHALL always be 4'b0000.
REQ-005 pipe  in  PipeControl  stall/flush for this stage's output registers.
REQ-006 info  in  DecodeInfo  instruction leaving execute (execute's info_ff).
REQ-007 alu_out  in  32  effective address for loads/stores, result otherwise.
REQ-008 r2_out  in  32  store data, unaligned (byte/half in low bits).
REQ-009 dbus_req  out  1  access request, held until dbus_gnt.
REQ-010 dbus_we  out  1  1 = store.
REQ-011 dbus_addr  out  32  word-aligned address ({alu_out[31:2],2'b00}).
REQ-012 dbus_be  out  4  byte enables.
REQ-013 dbus_wdata  out  32  store data replicated into lane(s).
REQ-014 dbus_gnt  in  1  request accepted this cycle.
REQ-015 dbus_rvalid  in  1  response (read data or store ack), exactly one per grant.
REQ-016 dbus_rdata  in  32  read data, valid with dbus_rvalid.
REQ-017 mem_out  out  32  registered stage result (load data or passed-through alu_out).
REQ-018 info_ff  out  DecodeInfo  registered instruction info for writeback.
REQ-019 misalign  out  1  registered one-cycle pulse: misaligned access suppressed.

Function
REQ-020 Access = info.enable & (mem_read | mem_write); funct3 000 byte, 001 half, 010 word, 100 LBU, 101 LHU; other funct3 misaligned-class, no bus access.
REQ-021 Misaligned: half with addr[0]=1, word with addr[1:0]!=0; no dbus_req, mem_out<=0, info_ff.rd_valid<=0, misalign<=1 for one cycle.
REQ-022 FSM states IDLE, REQ, RESP, DONE, DRAIN.
REQ-023 IDLE + valid access + !pipe.flush: dbus_req=1 combinationally same cycle, stall_req=1; gnt -> RESP else -> REQ.
REQ-024 REQ: dbus_req and all dbus_* held stable; gnt -> RESP; pipe.flush -> IDLE, dbus_req dropped.
REQ-025 RESP: stall_req=1 until dbus_rvalid; on rvalid stall_req=0 that cycle, result captured; pipe.stall=0 -> IDLE with output regs updated, pipe.stall=1 -> DONE.
REQ-026 DONE: result held in internal buffer, stall_req=0, no reissue; on !pipe.stall output regs load buffer -> IDLE.
REQ-027 pipe.flush in RESP -> DRAIN: stall_req=0, wait rvalid, discard data -> IDLE; new access not issued until IDLE.
REQ-028 Best case load/store latency: gnt same cycle as request, rvalid next cycle -> one stall cycle.
REQ-029 Load data: lane by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW unmodified.
REQ-030 Store: SB be=4'b0001<<addr[1:0], wdata={4{r2_out[7:0]}}; SH be=addr[1]?4'b1100:4'b0011, wdata={2{r2_out[15:0]}}; SW be=4'b1111.
REQ-031 Non-load (incl. store, ALU, JAL link): mem_out<=alu_out, so forwarding to execute sees correct value.
REQ-032 Output regs priority: flush (clear to 0) > stall (hold) > access-incomplete (load bubble: info_ff.enable=0) > update.
REQ-033 dbus_we/addr/be/wdata SHALL be 0 when dbus_req=0.

Reset
REQ-034 rst asynchronously forces IDLE, dbus_req=0, mem_out=0, info_ff=0, misalign=0, buffer=0; reset mid-access abandons transaction; a later stray rvalid in IDLE SHALL be ignored.

Structure
REQ-035 MemState enum and LSU funct3 constants SHALL live in common.sv alongside PipeRequest/PipeControl/DecodeInfo.
REQ-036 Byte-lane extract/extend and store replicate/be generation SHALL be combinational sub-module lsu_align.

Verification
REQ-037 LW addr 0x100, gnt same cycle, rvalid next with rdata 0xDEADBEEF -> one stall cycle, mem_out=0xDEADBEEF.
REQ-038 LB addr 0x103, rdata 0x80112233 -> mem_out=0xFFFFFF80; LBU same -> 0x00000080; LHU addr 0x102 -> 0x00008011.
REQ-039 SH addr 0x202, r2_out 0x1234ABCD -> be=4'b1100, wdata=0xABCDABCD, dbus_we=1; mem_out=0x202.
REQ-040 gnt delayed 3 cycles, rvalid 2 after; pipe.stall=1 for 2 cycles post-rvalid -> request stable, no reissue, stall_req low in DONE, result delivered once.
REQ-041 LW addr 0x101 -> no dbus_req, misalign pulse, info_ff.rd_valid=0; flush in RESP -> DRAIN discards 0x55AA55AA.
REQ-042 rst asserted in RESP -> dbus_req=0 immediately, outputs zero; rvalid next cycle ignored.
